// File: rtl/matrix_res_stream.sv
// -----------------------------------------------------------------------------
// matrix_res_stream
//
// Captures a HEIGHT_A x WIDTH_B product matrix in one cycle and streams its
// elements out one per accepted transfer, in row-major order, with a
// valid/ready handshake. Every output is a register.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   i_array_res  product matrix, element [r][c] is 2*BITS bits
//   i_load       capture request, honoured only while idle
//   i_ready      downstream accepts o_data this cycle
//   o_data       current element, raw two's-complement bits
//   o_valid      o_data holds a valid element
//   o_last       current element is [HEIGHT_A-1][WIDTH_B-1]
//   o_row/o_col  indices of the current element (0 while idle)
//   o_busy       high whenever a frame is in progress
// -----------------------------------------------------------------------------
module matrix_res_stream #(
    parameter  int BITS     = 8,
    parameter  int HEIGHT_A = 2,
    parameter  int WIDTH_B  = 3,
    localparam int DW       = 2 * BITS,
    localparam int RW       = (HEIGHT_A > 1) ? $clog2(HEIGHT_A) : 1,
    localparam int CW       = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [HEIGHT_A-1:0][WIDTH_B-1:0][DW-1:0] i_array_res,
    input  logic                                   i_load,
    input  logic                                   i_ready,
    output logic [DW-1:0]                          o_data,
    output logic                                   o_valid,
    output logic                                   o_last,
    output logic [RW-1:0]                          o_row,
    output logic [CW-1:0]                          o_col,
    output logic                                   o_busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_A - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_B - 1);

    logic [0:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          load_buf;

    logic [HEIGHT_A-1:0][WIDTH_B-1:0][DW-1:0] buf_q;

    // Outputs are registered, so the next-state logic also computes the next
    // output values: o_data is looked up from the *next* indices.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        load_buf = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    state_d  = ST_SEND;
                    row_d    = '0;
                    col_d    = '0;
                    // Buffer is written at this same edge, so take element
                    // [0][0] straight from the input.
                    data_d   = i_array_res[0][0];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    last_d   = (HEIGHT_A == 1) && (WIDTH_B == 1);
                    load_buf = 1'b1;
                end
            end
            ST_SEND: begin
                // i_load is deliberately not looked at here.
                if (i_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        col_d   = '0;
                        data_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        data_d = buf_q[row_d][col_d];
                        last_d = (row_d == ROW_LAST) && (col_d == COL_LAST);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the frame buffer has no reset; its contents are only read after a
    // fresh capture, so clearing it would add logic for no behavioural gain.
    always_ff @(posedge clk) begin
        if (load_buf && !reset) begin
            buf_q <= i_array_res;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_row   = row_q;
    assign o_col   = col_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_matrix_res_stream.sv
// -----------------------------------------------------------------------------
// tb_matrix_res_stream
//
// Self-checking bench for matrix_res_stream with default parameters (2x3,
// 16-bit elements). A queue-based reference model holds the elements still
// owed for the current frame; outputs are compared against it every cycle,
// plus a table of fixed expected outputs for the backpressure case.
// -----------------------------------------------------------------------------
module tb_matrix_res_stream;

    localparam int H  = 2;
    localparam int W  = 3;
    localparam int DW = 16;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [H-1:0][W-1:0][DW-1:0]   mat;
    logic                          load;
    logic                          ready;
    logic [DW-1:0]                 o_data;
    logic                          o_valid;
    logic                          o_last;
    logic [0:0]                    o_row;
    logic [1:0]                    o_col;
    logic                          o_busy;

    matrix_res_stream #(.BITS(8), .HEIGHT_A(H), .WIDTH_B(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_array_res (mat),
        .i_load      (load),
        .i_ready     (ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .o_row       (o_row),
        .o_col       (o_col),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            row;
        int            col;
        logic          last;
    } elem_t;

    elem_t owed[$];
    int    xfer_cnt   = 0;
    int    frames_done = 0;

    // Compare DUT outputs to what the model says should be on the bus now.
    task automatic compare_model();
        if (owed.size() == 0) begin
            check("idle_valid", 32'(o_valid), 32'd0);
            check("idle_data",  32'(o_data),  32'd0);
            check("idle_row",   32'(o_row),   32'd0);
            check("idle_col",   32'(o_col),   32'd0);
            check("idle_last",  32'(o_last),  32'd0);
            check("idle_busy",  32'(o_busy),  32'd0);
        end else begin
            check("valid", 32'(o_valid), 32'd1);
            check("data",  32'(o_data),  32'(owed[0].data));
            check("row",   32'(o_row),   32'(owed[0].row));
            check("col",   32'(o_col),   32'(owed[0].col));
            check("last",  32'(o_last),  32'(owed[0].last));
            check("busy",  32'(o_busy),  32'd1);
        end
    endtask

    // One clock cycle. Called just after a falling edge: check, drive, let the
    // rising edge happen, advance the model, return at the next falling edge.
    task automatic cycle(input logic ld, input logic rdy, input logic rst);
        compare_model();
        load  = ld;
        ready = rdy;
        reset = rst;
        if (!rst && o_valid && rdy) begin
            xfer_cnt++;
            if (o_last) begin
                check("frame_len", 32'(xfer_cnt), 32'd6);
                xfer_cnt = 0;
            end
        end
        if (rst) xfer_cnt = 0;
        @(posedge clk);
        if (rst) begin
            owed.delete();
        end else if (owed.size() == 0) begin
            if (ld) begin
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        owed.push_back('{data: mat[r][c], row: r, col: c,
                                         last: (r == H-1) && (c == W-1)});
            end
        end else if (rdy) begin
            void'(owed.pop_front());
            if (owed.size() == 0) frames_done++;
        end
        @(negedge clk);
    endtask

    task automatic set_mat(input int v00, input int v01, input int v02,
                           input int v10, input int v11, input int v12);
        mat[0][0] = DW'(v00); mat[0][1] = DW'(v01); mat[0][2] = DW'(v02);
        mat[1][0] = DW'(v10); mat[1][1] = DW'(v11); mat[1][2] = DW'(v12);
    endtask

    // ---------------- fixed vector table ----------------
    typedef struct {
        logic          ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        int            exp_row;
        int            exp_col;
        logic          exp_last;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Backpressure on element (0,1)=66 for three cycles, then drain.
        vecs[0] = '{1'b1, 1'b1, 16'd54,  0, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'd66,  0, 1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'd66,  0, 1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'd66,  0, 1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'd66,  0, 1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'd78,  0, 2, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 16'd90,  1, 0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'd111, 1, 1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'd132, 1, 2, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'd0,   0, 0, 1'b0};

        reset = 1'b1;
        load  = 1'b0;
        ready = 1'b0;
        set_mat(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, including reset winning over a simultaneous load.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);

        // Plain frame with ready held high.
        set_mat(54, 66, 78, 90, 111, 132);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        // Negative elements stream bit-exact.
        set_mat(1, 2, 3, 16'hFFEC, 16'hFFE7, 16'hFFE2);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (7) cycle(1'b0, 1'b1, 1'b0);

        // Table-driven backpressure run.
        set_mat(54, 66, 78, 90, 111, 132);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tv%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tv%0d_data", i),  32'(o_data),  32'(vecs[i].exp_data));
            check($sformatf("tv%0d_row", i),   32'(o_row),   32'(vecs[i].exp_row));
            check($sformatf("tv%0d_col", i),   32'(o_col),   32'(vecs[i].exp_col));
            check($sformatf("tv%0d_last", i),  32'(o_last),  32'(vecs[i].exp_last));
            cycle(1'b0, vecs[i].ready, 1'b0);
        end

        // Loads during SEND, input matrix changed after capture, load held at
        // the last transfer: all ignored, then at least one idle cycle.
        set_mat(10, 20, 30, 40, 50, 60);
        cycle(1'b1, 1'b1, 1'b0);
        set_mat(7, 7, 7, 7, 7, 7);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("idle_after_load_at_last", 32'(o_busy), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);

        // Reset after the third transfer, then a fresh frame right away.
        set_mat(5, 6, 7, 8, 9, 10);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        set_mat(11, 12, 13, 14, 15, 16);
        cycle(1'b1, 1'b1, 1'b0);
        check("fresh_frame_data", 32'(o_data), 32'd11);
        repeat (7) cycle(1'b0, 1'b1, 1'b0);

        // Random ready, random stray loads, 100 frames.
        begin
            int start_frames = frames_done;
            int budget = 0;
            while (frames_done - start_frames < 100 && budget < 5000) begin
                if (owed.size() == 0) begin
                    for (int r = 0; r < H; r++)
                        for (int c = 0; c < W; c++)
                            mat[r][c] = DW'($urandom);
                end
                cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
                budget++;
            end
            check("random_frames_done", 32'(frames_done - start_frames), 32'd100);
        end
        cycle(1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_res_stream.md
MATRIX_RES_STREAM -- requirements
Module: matrix_res_stream

Interface
REQ-001 The block SHALL have parameter BITS, default 8, meaning the element width of the multiplier operands.
REQ-002 The block SHALL have parameter HEIGHT_A, default 2, meaning the number of result rows.
REQ-003 The block SHALL have parameter WIDTH_B, default 3, meaning the number of result columns.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, with synchronous active-high reset.
REQ-006 The block SHALL have port i_array_res, input, [2*BITS-1:0] x [HEIGHT_A-1:0][WIDTH_B-1:0], the product matrix from matrix_mul.
REQ-007 The block SHALL have port i_load, input, 1 bit, a request to capture i_array_res.
REQ-008 The block SHALL have port i_ready, input, 1 bit, indicating that downstream accepts o_data.
REQ-009 The block SHALL have port o_data, output, 2*BITS bits, the current element as a raw two's-complement pattern.
REQ-010 The block SHALL have port o_valid, output, 1 bit, indicating that o_data holds a valid element.
REQ-011 The block SHALL have port o_last, output, 1 bit, marking element [HEIGHT_A-1][WIDTH_B-1].
REQ-012 The block SHALL have ports o_row and o_col, outputs, each $clog2 of its dimension (minimum 1 bit), giving the indices of the current element.
REQ-013 The block SHALL have port o_busy, output, 1 bit, which is high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and SEND, and all outputs SHALL be registered.
REQ-015 In IDLE, when i_load=1 at a clock edge, the block SHALL capture all of i_array_res into an internal buffer, clear row and col to 0, and enter SEND.
REQ-016 The first element SHALL be presented (o_valid=1, o_data=buf[0][0]) in the cycle immediately after the edge at which i_load was sampled, a latency of 1 cycle.
REQ-017 While in SEND, o_valid SHALL be 1 and o_data SHALL be buf[o_row][o_col].
REQ-018 A transfer SHALL occur at an edge where o_valid=1 and i_ready=1.
REQ-019 When o_valid=1 and i_ready=0, o_data, o_row, o_col and o_last SHALL hold stable.
REQ-020 On a transfer, col SHALL increment; when col=WIDTH_B-1 it SHALL wrap to 0 and row SHALL increment, giving row-major order.
REQ-021 o_last SHALL be 1 exactly when row=HEIGHT_A-1 and col=WIDTH_B-1 while o_valid=1.
REQ-022 On the transfer of the last element, the block SHALL return to IDLE; o_valid, o_last and o_busy SHALL read 0 in the next cycle.
REQ-023 i_load SHALL be ignored in SEND, including the cycle of the last transfer; a new capture requires i_load to be sampled in IDLE.
REQ-024 Changes on i_array_res after capture SHALL NOT affect the streamed values.
REQ-025 With i_ready held at 1, one frame SHALL take exactly HEIGHT_A*WIDTH_B cycles of o_valid, followed by at least 1 IDLE cycle.
REQ-026 o_data SHALL be passed bit-exact with no sign extension, truncation or arithmetic.
REQ-027 In IDLE, o_data, o_row and o_col SHALL read 0.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set the state to IDLE and o_valid, o_last, o_busy, o_data, o_row and o_col to 0; buffer contents are don't-care.
REQ-029 reset SHALL take priority over i_load and over any transfer in the same cycle.
REQ-030 If reset is asserted mid-frame, the block SHALL discard the remaining elements, emit no further o_valid, and accept a new i_load in the first cycle after reset deasserts.

Verification
REQ-031 The bench SHALL load [[54,66,78],[90,111,132]] with i_ready=1 -> o_data 54,66,78,90,111,132 on 6 consecutive cycles starting 1 cycle after i_load, with o_last only on 132 and (o_row,o_col) stepping (0,0)..(1,2).
REQ-032 The bench SHALL load [[1,2,3],[-20,-25,-30]] -> o_data 0x0001,0x0002,0x0003,0xFFEC,0xFFE7,0xFFE2.
REQ-033 The bench SHALL apply backpressure, holding i_ready=0 for 3 cycles while element (0,1)=66 is presented -> o_data=66 stable with o_valid=1 for 4 cycles, then the stream continues with no loss or duplication.
REQ-034 The bench SHALL pulse i_load during SEND, change i_array_res after capture, and hold i_load=1 at the last transfer -> these are ignored, the original frame is streamed intact, and the block returns to IDLE for at least 1 cycle.
REQ-035 The bench SHALL assert reset after the 3rd transfer -> all outputs read 0 the next cycle; after reset deasserts, a new i_load streams a fresh frame starting at (0,0).
REQ-036 The bench SHALL drive random i_ready over 100 frames against a scoreboard -> each frame yields exactly 6 transfers in row-major order and o_busy=0 between frames.
